// File: rtl/cpu_out_capture_if.sv
// Bundle between the capture block and its neighbours: the observed CPU bus and
// controls on one side, the valid/ready read port and status on the other.
interface cpu_out_capture_if #(
  parameter int unsigned DATA_W = 10,
  parameter int unsigned TS_W   = 16,
  parameter int unsigned DEPTH  = 8
);
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  logic              en;
  logic [DATA_W-1:0] cpu_out;
  logic              clr_ovf;
  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic [TS_W-1:0]   rd_ts;
  logic [LVL_W-1:0]  level;
  logic              overflow;
  logic [7:0]        drop_cnt;

  // Environment side: drives the CPU bus, controls and the consumer handshake.
  modport master (
    output en, cpu_out, clr_ovf, rd_ready,
    input  rd_valid, rd_data, rd_ts, level, overflow, drop_cnt
  );

  // Capture block side.
  modport slave (
    input  en, cpu_out, clr_ovf, rd_ready,
    output rd_valid, rd_data, rd_ts, level, overflow, drop_cnt
  );
endinterface

// File: rtl/cpu_out_capture.sv
// Watches the CPU output bus, records every value change with a free-running
// cycle stamp in a small FIFO and hands entries to a valid/ready consumer.
module cpu_out_capture #(
  parameter int unsigned DATA_W = 10,
  parameter int unsigned TS_W   = 16,
  parameter int unsigned DEPTH  = 8
) (
  input logic              clk,
  input logic              reset,
  cpu_out_capture_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
  localparam logic [TS_W-1:0]  TS_ONE   = TS_W'(1);
  localparam logic [7:0]       DROP_MAX = 8'hFF;

  logic [DATA_W-1:0] r_last;
  logic [TS_W-1:0]   r_ts;
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [LVL_W-1:0]  r_level;
  logic              r_overflow;
  logic [7:0]        r_drop_cnt;
  logic [DATA_W-1:0] r_mem_data [DEPTH];
  logic [TS_W-1:0]   r_mem_ts   [DEPTH];

  logic             w_evt;
  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic [LVL_W-1:0] w_level_d;

  // Event detection and FIFO handshake decode.
  always_comb begin
    w_evt   = bus.en && (bus.cpu_out != r_last);
    w_empty = (r_level == '0);
    w_full  = (r_level == LVL_FULL);
    // rd_valid is purely registered state, so pop never loops back into it.
    w_pop   = !w_empty && bus.rd_ready;
    // A full FIFO still accepts the event if the head leaves in the same cycle.
    w_push  = w_evt && (!w_full || w_pop);
    w_drop  = w_evt && w_full && !w_pop;
  end

  // Occupancy next state; simultaneous push and pop leave it unchanged.
  always_comb begin
    w_level_d = r_level;
    unique case ({w_push, w_pop})
      2'b10:   w_level_d = r_level + LVL_ONE;
      2'b01:   w_level_d = r_level - LVL_ONE;
      default: w_level_d = r_level;
    endcase
  end

  // Cycle stamp: counts every edge after reset release, regardless of en.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ts <= '0;
    end else begin
      r_ts <= r_ts + TS_ONE;
    end
  end

  // Last sampled bus value; follows the bus whenever enabled, even on drops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last <= '0;
    end else if (bus.en) begin
      r_last <= bus.cpu_out;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_ONE;
      end
      r_level <= w_level_d;
    end
  end

  // Entry storage; contents are masked at the outputs while empty, so no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wptr] <= bus.cpu_out;
      r_mem_ts[r_wptr]   <= r_ts;
    end
  end

  // Overflow flag and drop counter; a drop in the same cycle beats a clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (bus.clr_ovf) begin
        r_drop_cnt <= 8'd1;
      end else if (r_drop_cnt != DROP_MAX) begin
        r_drop_cnt <= r_drop_cnt + 8'd1;
      end
    end else if (bus.clr_ovf) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end
  end

  // Read port and status; head fields read zero while the FIFO is empty.
  always_comb begin
    bus.rd_valid = !w_empty;
    bus.rd_data  = w_empty ? '0 : r_mem_data[r_rptr];
    bus.rd_ts    = w_empty ? '0 : r_mem_ts[r_rptr];
    bus.level    = r_level;
    bus.overflow = r_overflow;
    bus.drop_cnt = r_drop_cnt;
  end
endmodule

// File: doc/cpu_out_capture.md
Name: cpu_out_capture

Overview:
- Receive-side companion to the RV_CPU 10-bit `out` port.
- Samples the CPU output bus every cycle and detects value changes.
- Stamps each change with a free-running cycle count and buffers it in a small FIFO.
- Presents entries to a downstream consumer (checker, UART bridge or debug logic) over a valid/ready interface.

Parameters:
- DATA_W, 10, width of the sampled CPU output bus
- TS_W, 16, width of the timestamp counter; wraps modulo 2^TS_W
- DEPTH, 8, FIFO entries; power of two, minimum 2

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-low reset (reset=0 resets; release is synchronous to clk)
- en  input  1  capture enable; 0 freezes change detection
- cpu_out  input  DATA_W  CPU output bus being observed
- clr_ovf  input  1  synchronous clear of overflow and drop_cnt
- rd_valid  output  1  FIFO non-empty; head entry is valid
- rd_ready  input  1  consumer accepts the head entry when rd_valid=1
- rd_data  output  DATA_W  head entry: captured cpu_out value
- rd_ts  output  TS_W  head entry: timestamp of the capture
- level  output  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH
- overflow  output  1  sticky; set when a change is dropped because the FIFO is full
- drop_cnt  output  8  saturating count of dropped changes

Behaviour:
- Reset (reset=0, asynchronous) forces:
  - last_q=0, ts counter=0, FIFO pointers=0
  - rd_valid=0, level=0, overflow=0, drop_cnt=0
  - rd_data and rd_ts read 0 while empty.
- Timestamp counter:
  - Increments by 1 on every clk edge after reset release, independent of en.
  - Wraps from 2^TS_W-1 to 0 with no flag.
- Change event:
  - At edge k, evt = en && (cpu_out != last_q).
  - If en=1, last_q <= cpu_out at every edge, whether or not the event is stored.
  - If en=0, last_q holds.
- Push:
  - An event stores {cpu_out, ts} into the FIFO at edge k, where ts is the counter value before the edge-k increment.
  - The entry is visible at the head with rd_valid=1 after edge k, giving 1-cycle latency from sample to valid.
- Pop:
  - Occurs when rd_valid && rd_ready at an edge.
  - The head advances. rd_data and rd_ts change only on pop or on a push into an empty FIFO.
  - rd_ready while empty has no effect.
- Ordering: strict FIFO order, no reordering and no coalescing.
- Full (level=DEPTH) with an event and no pop:
  - The event is dropped and overflow <= 1.
  - drop_cnt increments and saturates at 255.
  - last_q still updates.
- Full with an event and a pop in the same cycle: the push is accepted and level stays DEPTH.
- Empty with an event and rd_ready=1 in the same cycle: the push is stored and no pop occurs (rd_valid was 0). rd_valid rises the next cycle.
- Push and pop in the same cycle while not empty and not full: level is unchanged.
- clr_ovf=1:
  - overflow <= 0 and drop_cnt <= 0 at the edge.
  - If a drop happens in the same cycle, the drop wins: overflow=1, drop_cnt=1.
- Pointers wrap modulo DEPTH. Full/empty are distinguished by level, or by an extra pointer bit.
- Reset asserted mid-operation discards all FIFO contents immediately. The first cycle after release behaves as after power-up, so a nonzero cpu_out is captured with ts=0.
- No combinational path from rd_ready to rd_valid.

Test Plan:
- Basic capture:
  - Stimulus: reset low 5 cycles, release, en=1, cpu_out=0 for 3 cycles, then 10'h155 at the sampling edge where ts=3, rd_ready=1.
  - Required: one entry rd_data=10'h155, rd_ts=3, rd_valid high for exactly 1 cycle. A constant value produces no further entries.
- Back-to-back changes:
  - Stimulus: cpu_out steps 1,2,3,4 on consecutive edges, rd_ready=0.
  - Required: level=4. Entries then drain in order 1,2,3,4 with consecutive timestamps.
- Overflow:
  - Stimulus: DEPTH=8, rd_ready=0, 11 distinct consecutive values.
  - Required: level=8, overflow=1, drop_cnt=3. The first 8 values are retained.
  - Then clr_ovf=1 for one cycle gives overflow=0, drop_cnt=0.
- Full with simultaneous pop:
  - Stimulus: FIFO full, rd_ready=1 and a new value in the same cycle.
  - Required: level stays 8, drop_cnt unchanged, the new value is at the tail.
- Enable gating and timestamp wrap:
  - Stimulus: en=0 while cpu_out toggles.
  - Required: no entries.
  - Stimulus: run 65536+2 cycles and change cpu_out at count 65537.
  - Required: rd_ts=1.
- Mid-operation reset:
  - Stimulus: with 5 entries queued, pull reset low for 1 cycle.
  - Required: rd_valid=0, level=0, overflow=0 immediately (asynchronous). After release, a held cpu_out=10'h3FF is captured with rd_ts=0.
